// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT sink framing path.
package fft_pkg;

   localparam int unsigned FFT_DATA_W      = 14;
   localparam int unsigned FFT_LEN_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } framer_state_t;

   // Bits needed to index n items, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((64'(1) << r) < 64'(n)) r++;
      return r;
   endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; head entry drives the output directly.
module fft_skid_fifo
   import fft_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic         empty_q, empty_d;
   logic         full_q, full_d;
   logic         do_pop;
   logic         do_push;

   // Next-state: a push into a full FIFO is only accepted alongside a pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      empty_d = empty_q;
      full_d  = full_q;
      do_pop  = pop && !empty_q;
      do_push = push && (!full_q || do_pop);
      case ({do_push, do_pop})
         2'b10: begin
            if (empty_q) begin
               head_d  = din;
               empty_d = 1'b0;
            end else begin
               tail_d = din;
               full_d = 1'b1;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            full_d  = 1'b0;
            empty_d = !full_q;
         end
         2'b11: begin
            if (full_q) begin
               head_d = tail_q;
               tail_d = din;
            end else begin
               head_d = din;
            end
         end
         default: ;
      endcase
   end

   // Storage and occupancy flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   assign dout  = head_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/fft_sink_framer.sv
// Channel select, decimation and FFT_LEN framing in front of the FFT sink port.
module fft_sink_framer
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W     = FFT_DATA_W,
   parameter int unsigned FFT_LEN    = FFT_LEN_DEFAULT,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               enable,
   input  logic [clog2_min1(NUM_CH)-1:0]      ch_sel,
   input  logic [7:0]                         decim,
   input  logic [NUM_CH*DATA_W-1:0]           in_data,
   input  logic                               in_valid,
   input  logic                               sink_ready,
   output logic                               sink_valid,
   output logic                               sink_sop,
   output logic                               sink_eop,
   output logic [DATA_W-1:0]                  sink_real,
   output logic [DATA_W-1:0]                  sink_imag,
   output logic [clog2_min1(NUM_CH)-1:0]      sink_channel,
   output logic                               busy,
   output logic                               overflow,
   input  logic                               clr_ovf,
   output logic [15:0]                        frame_cnt
);

   localparam int unsigned CH_W     = clog2_min1(NUM_CH);
   localparam int unsigned IDX_W    = clog2_min1(FFT_LEN);
   localparam int unsigned GAP_W    = clog2_min1(GAP_CYCLES + 1);
   localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
   localparam int unsigned FIFO_W   = DATA_W + CH_W + 2;

   framer_state_t     state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [7:0]        reload_q, reload_d;
   logic [7:0]        dcnt_q, dcnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              busy_q, busy_d;

   logic [DATA_W-1:0] sel_data;
   logic              start;
   logic              frame_end;
   logic              push;
   logic              pop;
   logic              fifo_ok;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_W-1:0] fifo_din;
   logic [FIFO_W-1:0] fifo_dout;

   // Channel mux driven by the channel latched at frame start.
   always_comb begin
      sel_data = in_data[DATA_W-1:0];
      for (int c = 0; c < int'(NUM_CH); c++) begin
         if (int'(ch_q) == c) sel_data = in_data[c*DATA_W +: DATA_W];
      end
   end

   assign pop      = !fifo_empty && sink_ready;
   assign fifo_ok  = !fifo_full || pop;
   assign fifo_din = {sel_data, ch_q, (idx_q == '0), (idx_q == IDX_W'(FFT_LEN - 1))};

   // Framing FSM, decimation/index/gap counters and status flags.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      reload_d    = reload_q;
      dcnt_d      = dcnt_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      overflow_d  = overflow_q;
      frame_cnt_d = frame_cnt_q;
      start       = 1'b0;
      frame_end   = 1'b0;
      push        = 1'b0;

      if (clr_ovf) overflow_d = 1'b0;
      if (pop && fifo_dout[0]) frame_cnt_d = frame_cnt_q + 16'd1;

      case (state_q)
         IDLE: begin
            if (enable) start = 1'b1;
         end
         RUN: begin
            if (in_valid) begin
               if (dcnt_q == 8'd0) begin
                  dcnt_d = reload_q;
                  if (fifo_ok) begin
                     push = 1'b1;
                     if (idx_q == IDX_W'(FFT_LEN - 1)) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                     end else begin
                        idx_d = idx_q + IDX_W'(1);
                     end
                  end else begin
                     // Drop the sample; index holds so the frame stays whole.
                     overflow_d = 1'b1;
                  end
               end else begin
                  dcnt_d = dcnt_q - 8'd1;
               end
            end
            if (frame_end) begin
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  gap_d   = '0;
               end else if (enable) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_W'(GAP_LAST)) begin
               if (enable) start = 1'b1;
               else        state_d = IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame start: latch channel and decimation, restart the counters.
      if (start) begin
         state_d  = RUN;
         ch_d     = (32'(ch_sel) < NUM_CH) ? ch_sel : '0;
         reload_d = (decim == 8'd0) ? 8'd0 : decim - 8'd1;
         dcnt_d   = 8'd0;
         idx_d    = '0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         reload_q    <= 8'd0;
         dcnt_q      <= 8'd0;
         idx_q       <= '0;
         gap_q       <= '0;
         overflow_q  <= 1'b0;
         frame_cnt_q <= 16'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         reload_q    <= reload_d;
         dcnt_q      <= dcnt_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         overflow_q  <= overflow_d;
         frame_cnt_q <= frame_cnt_d;
         busy_q      <= busy_d;
      end
   end

   fft_skid_fifo #(
      .W (FIFO_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (fifo_din),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign sink_valid   = !fifo_empty;
   assign sink_real    = fifo_dout[FIFO_W-1 -: DATA_W];
   assign sink_channel = fifo_dout[2 +: CH_W];
   assign sink_sop     = fifo_dout[1];
   assign sink_eop     = fifo_dout[0];
   assign sink_imag    = '0;
   assign busy         = busy_q;
   assign overflow     = overflow_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_fft_sink_framer.sv
// Scoreboard bench for fft_sink_framer (FFT_LEN=8, two channels) plus a GAP_CYCLES=3 instance.
module tb_fft_sink_framer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable, en_g;
   logic [0:0]  ch_sel;
   logic [7:0]  decim;
   logic [27:0] in_data;
   logic        in_valid;
   logic        sink_ready;
   logic        clr_ovf;

   logic        sink_valid, sink_sop, sink_eop, busy, overflow;
   logic [13:0] sink_real, sink_imag;
   logic [0:0]  sink_channel;
   logic [15:0] frame_cnt;

   logic        sink_valid_g, sink_sop_g, sink_eop_g, busy_g, overflow_g;
   logic [13:0] sink_real_g, sink_imag_g;
   logic [0:0]  sink_channel_g;
   logic [15:0] frame_cnt_g;

   typedef struct packed {
      logic [13:0] d;
      logic        sop;
      logic        eop;
      logic        ch;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   errs    = 0;

   always #5 clk = ~clk;

   fft_sink_framer #(.DATA_W(14), .FFT_LEN(8), .NUM_CH(2), .GAP_CYCLES(0)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .ch_sel(ch_sel), .decim(decim),
      .in_data(in_data), .in_valid(in_valid), .sink_ready(sink_ready),
      .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
      .sink_real(sink_real), .sink_imag(sink_imag), .sink_channel(sink_channel),
      .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf), .frame_cnt(frame_cnt)
   );

   fft_sink_framer #(.DATA_W(14), .FFT_LEN(8), .NUM_CH(2), .GAP_CYCLES(3)) dut_g (
      .clk(clk), .reset_n(reset_n), .enable(en_g), .ch_sel(ch_sel), .decim(decim),
      .in_data(in_data), .in_valid(in_valid), .sink_ready(sink_ready),
      .sink_valid(sink_valid_g), .sink_sop(sink_sop_g), .sink_eop(sink_eop_g),
      .sink_real(sink_real_g), .sink_imag(sink_imag_g), .sink_channel(sink_channel_g),
      .busy(busy_g), .overflow(overflow_g), .clr_ovf(clr_ovf), .frame_cnt(frame_cnt_g)
   );

   task automatic chk(input string nm, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic ex(input int d, input logic s, input logic e, input logic c);
      exp_t t;
      t.d = 14'(d); t.sop = s; t.eop = e; t.ch = c;
      q.push_back(t);
   endtask

   // One cycle of stimulus, applied just after the rising edge.
   task automatic step(input logic en, input logic eng, input logic rdy,
                       input logic v, input int d0, input int d1);
      @(posedge clk); #1;
      enable = en; en_g = eng; sink_ready = rdy; in_valid = v;
      in_data = {14'(d1), 14'(d0)};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
   endtask

   // Monitor: every word accepted by the sink is checked against the scoreboard.
   always @(negedge clk) begin
      if (reset_n && sink_valid && sink_ready) begin
         vectors++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_word: got d=%0d sop=%0b eop=%0b ch=%0d, expected no word",
                     sink_real, sink_sop, sink_eop, sink_channel);
         end else begin
            mon_e = q.pop_front();
            if (sink_real !== mon_e.d || sink_sop !== mon_e.sop || sink_eop !== mon_e.eop ||
                sink_channel !== mon_e.ch || sink_imag !== 14'd0) begin
               errs++;
               $display("FAIL word: got d=%0d sop=%0b eop=%0b ch=%0d im=%0d, expected d=%0d sop=%0b eop=%0b ch=%0d im=0",
                        sink_real, sink_sop, sink_eop, sink_channel, sink_imag,
                        mon_e.d, mon_e.sop, mon_e.eop, mon_e.ch);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; enable = 1'b0; en_g = 1'b0; ch_sel = 1'b0; decim = 8'd1;
      in_data = '0; in_valid = 1'b0; sink_ready = 1'b1; clr_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", sink_valid, 0);
      chk("rst_sop", sink_sop, 0);
      chk("rst_eop", sink_eop, 0);
      chk("rst_real", sink_real, 0);
      chk("rst_chan", sink_channel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_fcnt", frame_cnt, 0);
      reset_n = 1'b1;

      // Basic two back-to-back frames on ch1
      ch_sel = 1'b1; decim = 8'd1;
      step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         ex(k, (k == 1 || k == 9), (k == 8 || k == 16), 1'b1);
         step((k < 10), 1'b0, 1'b1, 1'b1, k + 50, k);
         if (k == 2) chk("busy_run", busy, 1);
      end
      idle(3);
      chk("fcnt_basic", frame_cnt, 2);
      chk("busy_idle", busy, 0);

      // Decimation by 3 on ch0
      ch_sel = 1'b0; decim = 8'd3;
      step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int k = 0; k <= 23; k++) begin
         if (k % 3 == 0) ex(k, (k == 0), (k == 21), 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b1, k, k + 100);
      end
      idle(3);

      // decim = 0 behaves as 1
      ch_sel = 1'b1; decim = 8'd0;
      step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         ex(30 + k, (k == 1), (k == 8), 1'b1);
         step(1'b0, 1'b0, 1'b1, 1'b1, k, 30 + k);
      end
      idle(3);

      // Back-pressure: samples 3 and 4 dropped, frame still 8 words
      ch_sel = 1'b0; decim = 8'd1;
      ex(1, 1'b1, 1'b0, 1'b0);
      ex(2, 1'b0, 1'b0, 1'b0);
      for (int k = 5; k <= 10; k++) ex(k, 1'b0, (k == 10), 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1, k, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      chk("bp_valid", sink_valid, 1);
      chk("bp_hold_real", sink_real, 1);
      chk("bp_hold_sop", sink_sop, 1);
      chk("bp_ovf", overflow, 1);
      for (int k = 5; k <= 10; k++) step(1'b0, 1'b0, 1'b1, 1'b1, k, 0);
      idle(3);
      chk("ovf_sticky", overflow, 1);
      clr_ovf = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      clr_ovf = 1'b0;
      chk("ovf_clr", overflow, 0);

      // Channel change mid-frame applies at the next frame
      ch_sel = 1'b0; decim = 8'd1;
      step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int k = 1; k <= 16; k++) begin
         if (k == 4) ch_sel = 1'b1;
         if (k <= 8) ex(100 + k, (k == 1), (k == 8), 1'b0);
         else        ex(200 + k, (k == 9), (k == 16), 1'b1);
         step((k < 10), 1'b0, 1'b1, 1'b1, 100 + k, 200 + k);
      end
      idle(3);
      chk("fcnt_chsw", frame_cnt, 7);

      // Reset at sample 5: frame abandoned
      ch_sel = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) ex(60 + k, (k == 1), 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b1, 1'b1, k, 60 + k);
      end
      @(posedge clk); #1;
      reset_n = 1'b0; in_valid = 1'b0;
      #1;
      chk("mrst_valid", sink_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_fcnt", frame_cnt, 0);
      chk("mrst_real", sink_real, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int k = 1; k <= 8; k++) begin
         ex(70 + k, (k == 1), (k == 8), 1'b1);
         step(1'b0, 1'b0, 1'b1, 1'b1, k, 70 + k);
      end
      idle(3);
      chk("fcnt_after_rst", frame_cnt, 1);

      // Stop with GAP_CYCLES=3 instance
      ch_sel = 1'b0; decim = 8'd1;
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      for (int k = 1; k <= 8; k++) step(1'b0, (k < 4), 1'b1, 1'b1, k, 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 99, 0);
      chk("gap_busy0", busy_g, 1);
      chk("gap_last_valid", sink_valid_g, 1);
      chk("gap_last_eop", sink_eop_g, 1);
      chk("gap_last_real", sink_real_g, 8);
      step(1'b0, 1'b0, 1'b1, 1'b1, 99, 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 99, 0);
      chk("gap_busy2", busy_g, 1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 99, 0);
      chk("gap_idle_busy", busy_g, 0);
      chk("gap_discard", sink_valid_g, 0);
      chk("gap_fcnt", frame_cnt_g, 1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 50, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      chk("regap_valid", sink_valid_g, 1);
      chk("regap_sop", sink_sop_g, 1);
      chk("regap_real", sink_real_g, 50);

      idle(3);
      chk("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/fft_sink_framer.md
# fft_sink_framer

Parametrised framing front-end between the NCO/ADC sample stream and the FFT core sink port. It selects one of `NUM_CH` input channels and decimates the selected stream by a runtime factor. It packs the accepted samples into Avalon-ST frames of `FFT_LEN` samples with `sink_sop`, `sink_eop` and `sink_valid`, and honours FFT back-pressure through a 2-entry skid FIFO. It supersedes the fixed single-channel, always-valid framing in the current FFT wrapper.

## Interface
Parameters:
- `DATA_W`, 14, sample width (signed two's complement)
- `FFT_LEN`, 1024, samples per frame; power of two, 8..65536
- `NUM_CH`, 2, number of input channels, 1..8
- `GAP_CYCLES`, 0, idle cycles forced between frames (0 = back-to-back)

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous active-low reset
- `enable`  in  1  start/continue framing; low = stop after current frame
- `ch_sel`  in  clog2(NUM_CH) (min 1)  channel for next frame, sampled at frame start
- `decim`  in  8  decimation factor, sampled at frame start; 0 treated as 1
- `in_data`  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- `in_valid`  in  1  all channels valid this cycle
- `sink_ready`  in  1  FFT core ready
- `sink_valid`  out  1  output sample valid
- `sink_sop`  out  1  first sample of frame
- `sink_eop`  out  1  last sample of frame
- `sink_real`  out  DATA_W  selected sample
- `sink_imag`  out  DATA_W  constant 0
- `sink_channel`  out  clog2(NUM_CH) (min 1)  channel of current frame
- `busy`  out  1  state != IDLE
- `overflow`  out  1  sticky; a sample was dropped
- `clr_ovf`  in  1  synchronous clear of `overflow`
- `frame_cnt`  out  16  completed frames issued, wraps at 65535->0

## Operation
- States: IDLE, RUN, GAP.
- IDLE -> RUN when `enable`=1. On entry, latch `ch_sel` and `decim`, clear the sample index and decimation counter, and mark the next accepted sample as SOP.
- RUN: each `in_valid` cycle decrements the decimation counter. A sample is taken when the counter is 0, and the counter then reloads to `decim`-1.
- A taken sample is pushed to the FIFO with SOP = (index==0) and EOP = (index==FFT_LEN-1). Only pushed samples advance the index.
- FIFO full when a sample is taken: the sample is dropped, `overflow` is set, and the index does not advance. Frame integrity is preserved: every frame is exactly FFT_LEN samples, SOP..EOP.
- The EOP push ends the frame:
  - if `GAP_CYCLES`>0, go to GAP;
  - else if `enable`, start a new frame immediately (re-latch `ch_sel`/`decim`);
  - else go to IDLE.
- GAP: count `GAP_CYCLES` cycles, discarding input. Then go to RUN (re-latch) if `enable`, else IDLE.
- `enable` falling mid-frame has no effect until EOP.
- `frame_cnt` increments when the EOP word is popped (`sink_valid && sink_ready && sink_eop`).
- `overflow`: set has priority over a same-cycle `clr_ovf`.
- Out-of-range `ch_sel` (>= NUM_CH) latches as channel 0.

## Timing
- Reset (async assert, sync-released internally by flop design): state IDLE, all outputs 0, FIFO empty, counters 0.
- Latency: sample taken on edge t is visible on `sink_*` after edge t+1 (`sink_valid`=1 in cycle t+1), provided the FIFO was empty.
- Output handshake: `sink_*` are held stable while `sink_valid && !sink_ready`. A pop occurs on an edge with `sink_valid && sink_ready`.
- Push and pop can occur in the same cycle: occupancy is unchanged, no overflow.
- FIFO full = 2 entries. With `sink_ready` low, the third taken sample overflows.
- Throughput: 1 sample/cycle with `decim`=1 and `sink_ready` held high.
- Reset mid-frame: the frame is abandoned immediately. No EOP is issued, and `frame_cnt` is not incremented.

## Structure
- Shared package `fft_pkg`:
  - `FFT_DATA_W` default, `FFT_LEN_DEFAULT`;
  - state enum type `framer_state_t` {IDLE, RUN, GAP};
  - function `clog2_min1`.
- Sub-module `fft_skid_fifo`: 2-entry FWFT FIFO, width DATA_W+clog2(NUM_CH)+2 (data, channel, sop, eop), with push/pop/full/empty.
- Top: FSM, decimation counter, index counter, gap counter, channel mux, flags.

## Test plan
(DATA_W=14, FFT_LEN=8, NUM_CH=2, GAP_CYCLES=0 unless stated.)
- Basic frame: `enable`=1, `ch_sel`=1, `decim`=1, ch1 ramp 1..16, `sink_ready`=1 -> two frames. Frame 1 is 1..8, frame 2 is 9..16. SOP on 1 and 9, EOP on 8 and 16, `sink_channel`=1, `frame_cnt`=2, `sink_imag`=0.
- Decimation: `decim`=3, ramp 0..23 -> frame is 0,3,6,...,21. `decim`=0 behaves as 1.
- Back-pressure/overflow: `sink_ready`=0 for 4 taken samples -> the first 2 are held stable and the rest are dropped, `overflow`=1. On release, the frame still completes with exactly 8 samples, SOP..EOP.
- Channel switch at boundary: `ch_sel` 0->1 mid-frame -> the current frame stays on ch0 and the next frame is ch1.
- Stop and gap: GAP_CYCLES=3. `enable` dropped at sample 4 -> the frame completes, then 3 gap cycles, then IDLE, `busy`=0. Re-enable -> new SOP.
- Reset mid-frame at sample 5 -> all outputs 0 next cycle. After release, the first frame starts with SOP and `frame_cnt`=0.
